// File: rtl/tdline_tap_monitor.sv
// Run-time checker for a 5-tap delay line: synchronizes the taps, follows an edge along the
// line and reports pulse width / end-to-end span, flagging out-of-order or stuck edges.
module tdline_tap_monitor #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       tap,
   input  logic             clr_err,
   output logic [2:0]       state,
   output logic             done,
   output logic [CNT_W-1:0] width,
   output logic [CNT_W-1:0] span,
   output logic             err_order,
   output logic             err_timeout,
   output logic             err_sticky
);

   localparam int unsigned       TCNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TcntLast = TCNT_W'(TIMEOUT - 1);
   localparam logic [4:0]        AllOnes  = 5'b11111;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRise   = 3'd1,
      StHigh   = 3'd2,
      StFall   = 3'd3,
      StResync = 3'd4
   } state_e;

   logic [4:0]        sync_q [SYNC_STAGES];
   logic [4:0]        s;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d, scnt_q, scnt_d;
   logic [CNT_W-1:0]  span_nx_q, span_nx_d, width_nx_q, width_nx_d;
   logic [CNT_W-1:0]  width_q, width_d, span_q, span_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic [4:0]        lvl_q, lvl_d;
   logic              done_q, done_d, eo_q, eo_d, et_q, et_d, sticky_q, sticky_d;
   logic              is_rise, is_fall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= tap;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign s       = sync_q[SYNC_STAGES-1];
   assign is_rise = s inside {5'b00001, 5'b00011, 5'b00111, 5'b01111};
   assign is_fall = s inside {5'b11110, 5'b11100, 5'b11000, 5'b10000};

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      scnt_d     = scnt_q;
      tcnt_d     = tcnt_q;
      lvl_d      = lvl_q;
      span_nx_d  = span_nx_q;
      width_nx_d = width_nx_q;
      width_d    = width_q;
      span_d     = span_q;
      done_d     = 1'b0;
      eo_d       = 1'b0;
      et_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s == '0) begin
               state_d = StIdle;
            end else if (is_rise) begin
               state_d = StRise;
               wcnt_d  = CNT_W'(1);
               scnt_d  = CNT_W'(1);
               tcnt_d  = '0;
               lvl_d   = s;
            end else if (s == AllOnes) begin
               state_d   = StHigh;
               wcnt_d    = CNT_W'(1);
               span_nx_d = CNT_W'(1);
            end else begin
               eo_d    = 1'b1;
               state_d = StResync;
            end
         end
         StRise: begin
            wcnt_d = sat_inc(wcnt_q);
            scnt_d = sat_inc(scnt_q);
            tcnt_d = tcnt_q + TCNT_W'(1);
            if (s == AllOnes) begin
               state_d   = StHigh;
               span_nx_d = sat_inc(scnt_q);
            end else if (is_rise && ((s & lvl_q) == lvl_q)) begin
               lvl_d = s;
               if (tcnt_q == TcntLast) begin
                  et_d    = 1'b1;
                  state_d = StResync;
               end
            end else begin
               eo_d    = 1'b1;
               state_d = StResync;
            end
         end
         StHigh: begin
            if (s == AllOnes) begin
               wcnt_d = sat_inc(wcnt_q);
            end else if (is_fall) begin
               state_d    = StFall;
               width_nx_d = wcnt_q;
               tcnt_d     = '0;
               lvl_d      = s;
            end else if (s == '0) begin
               // Every tap dropped between two samples: the pulse ends here.
               state_d = StIdle;
               width_d = wcnt_q;
               span_d  = span_nx_q;
               done_d  = 1'b1;
            end else begin
               eo_d    = 1'b1;
               state_d = StResync;
            end
         end
         StFall: begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            if (s == '0) begin
               state_d = StIdle;
               width_d = width_nx_q;
               span_d  = span_nx_q;
               done_d  = 1'b1;
            end else if (is_fall && ((s & ~lvl_q) == '0)) begin
               lvl_d = s;
               if (tcnt_q == TcntLast) begin
                  et_d    = 1'b1;
                  state_d = StResync;
               end
            end else begin
               eo_d    = 1'b1;
               state_d = StResync;
            end
         end
         StResync: begin
            if (s == '0) begin
               state_d = StIdle;
            end else if (s == AllOnes) begin
               // Rise was not observed, so the span of this pulse is unknown.
               state_d   = StHigh;
               wcnt_d    = CNT_W'(1);
               span_nx_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      sticky_d = eo_d | et_d | (sticky_q & ~clr_err);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wcnt_q     <= '0;
         scnt_q     <= '0;
         tcnt_q     <= '0;
         lvl_q      <= '0;
         span_nx_q  <= '0;
         width_nx_q <= '0;
         width_q    <= '0;
         span_q     <= '0;
         done_q     <= 1'b0;
         eo_q       <= 1'b0;
         et_q       <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         scnt_q     <= scnt_d;
         tcnt_q     <= tcnt_d;
         lvl_q      <= lvl_d;
         span_nx_q  <= span_nx_d;
         width_nx_q <= width_nx_d;
         width_q    <= width_d;
         span_q     <= span_d;
         done_q     <= done_d;
         eo_q       <= eo_d;
         et_q       <= et_d;
         sticky_q   <= sticky_d;
      end
   end

   assign state       = state_q;
   assign done        = done_q;
   assign width       = width_q;
   assign span        = span_q;
   assign err_order   = eo_q;
   assign err_timeout = et_q;
   assign err_sticky  = sticky_q;

endmodule
